if_fetch_unit: RTL and testbench

Instruction-fetch front end that drives the synchronous instruction memory and consumes its read data. It holds the PC, issues one word-address per cycle to the memory (1-cycle read latency), and pairs each returned word with its PC. It delivers instructions to the ID stage with stall backpressure (1-entry skid buffer) and branch/jump redirect with squash of in-flight fetches.

---
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, 1-cycle synchronous IMEM read,
// and delivery to ID with a one-entry skid buffer plus redirect/squash.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    // PCs are kept as word addresses internally; byte bits [1:0] are always zero.
    logic [29:0] fetch_wa_q, fetch_wa_d;
    logic        f_vld_q, f_vld_d;
    logic [29:0] f_wa_q, f_wa_d;
    logic        s_vld_q, s_vld_d;
    logic [29:0] s_wa_q, s_wa_d;
    logic [31:0] s_instr_q, s_instr_d;
    logic        o_vld_q, o_vld_d;
    logic [31:0] o_pc_q, o_pc_d;
    logic [31:0] o_pc4_q, o_pc4_d;
    logic [31:0] o_instr_q, o_instr_d;

    logic advance;
    logic issue;
    logic unused_lsbs;

    assign advance     = !stall || !o_vld_q;
    assign issue       = !redirect_valid && advance;
    assign unused_lsbs = ^redirect_pc[1:0];

    assign imem_addr   = {2'b00, fetch_wa_q};
    assign if_valid    = o_vld_q;
    assign if_instr    = o_instr_q;
    assign if_pc       = o_pc_q;
    assign if_pc_plus4 = o_pc4_q;

    always_comb begin
        fetch_wa_d = fetch_wa_q;
        f_vld_d    = 1'b0;
        f_wa_d     = f_wa_q;
        s_vld_d    = s_vld_q;
        s_wa_d     = s_wa_q;
        s_instr_d  = s_instr_q;
        o_vld_d    = o_vld_q;
        o_pc_d     = o_pc_q;
        o_pc4_d    = o_pc4_q;
        o_instr_d  = o_instr_q;

        if (redirect_valid) begin
            // Squash everything younger than the branch; the word returning next cycle is dropped.
            fetch_wa_d = redirect_pc[31:2];
            s_vld_d    = 1'b0;
            o_vld_d    = 1'b0;
            o_instr_d  = NOP_INSTR;
        end else begin
            if (issue) begin
                f_vld_d    = 1'b1;
                f_wa_d     = fetch_wa_q;
                fetch_wa_d = fetch_wa_q + 30'd1;
            end

            if (advance) begin
                if (s_vld_q) begin
                    o_vld_d   = 1'b1;
                    o_pc_d    = {s_wa_q, 2'b00};
                    o_pc4_d   = {s_wa_q, 2'b00} + 32'd4;
                    o_instr_d = s_instr_q;
                    s_vld_d   = 1'b0;
                end else if (f_vld_q) begin
                    o_vld_d   = 1'b1;
                    o_pc_d    = {f_wa_q, 2'b00};
                    o_pc4_d   = {f_wa_q, 2'b00} + 32'd4;
                    o_instr_d = imem_data;
                end else begin
                    o_vld_d   = 1'b0;
                    o_instr_d = NOP_INSTR;
                end
            end else if (f_vld_q) begin
                // Output is held, so the returning word parks in the skid entry.
                s_vld_d   = 1'b1;
                s_wa_d    = f_wa_q;
                s_instr_d = imem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_wa_q <= RESET_PC[31:2];
            f_vld_q    <= 1'b0;
            s_vld_q    <= 1'b0;
            o_vld_q    <= 1'b0;
            o_instr_q  <= NOP_INSTR;
            o_pc_q     <= 32'd0;
            o_pc4_q    <= 32'd0;
        end else begin
            fetch_wa_q <= fetch_wa_d;
            f_vld_q    <= f_vld_d;
            s_vld_q    <= s_vld_d;
            o_vld_q    <= o_vld_d;
            o_instr_q  <= o_instr_d;
            o_pc_q     <= o_pc_d;
            o_pc4_q    <= o_pc4_d;
        end
    end

    always_ff @(posedge clk) begin
        f_wa_q    <= f_wa_d;
        s_wa_q    <= s_wa_d;
        s_instr_q <= s_instr_d;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stall/redirect/reset
// traffic, checked against a program-order stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks   = 0;
    int failures = 0;

    // Stream model: where the next delivered instruction must come from,
    // how many cycles remain before delivery starts, and the next fetch address.
    logic        known    = 1'b0;
    int          inv_left = 0;
    logic [31:0] exp_pc   = 32'd0;
    logic [31:0] exp_addr = 32'd0;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [3:0] n;
        if (a == 30'd0) return 32'hA000_00AA;
        if (a < 30'd16) begin
            n = a[3:0];
            return {n, 20'h00000, n, n};
        end
        return {a[27:0], 4'h5} ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk) imem_data <= mem_word(imem_addr[29:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_valid;
        if (known) begin
            exp_valid = (inv_left == 0);
            chk("valid", {31'b0, if_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk("pc", if_pc, exp_pc);
                chk("instr", if_instr, mem_word(exp_pc[31:2]));
                chk("pc_plus4", if_pc_plus4, exp_pc + 32'd4);
            end else begin
                chk("nop", if_instr, NOP_INSTR);
            end
            chk("imem_addr", imem_addr, exp_addr);
            chk("skid_inflight_excl", {31'b0, dut.s_vld_q & dut.f_vld_q}, 32'd0);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        logic valid_now;
        if (r) begin
            known    = 1'b1;
            inv_left = 2;
            exp_pc   = RESET_PC;
            exp_addr = {2'b00, RESET_PC[31:2]};
        end else if (known) begin
            valid_now = (inv_left == 0);
            if (rv) begin
                inv_left = 2;
                exp_pc   = {rp[31:2], 2'b00};
                exp_addr = {2'b00, rp[31:2]};
            end else begin
                if (valid_now && !s) exp_pc = exp_pc + 32'd4;
                if (inv_left > 0) inv_left--;
                if (!s || !valid_now) exp_addr = (exp_addr + 32'd1) & 32'h3FFF_FFFF;
            end
        end
    endtask

    // One clock cycle: drive inputs, check what is visible now, then take the edge.
    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        #1;
        check_outputs();
        @(posedge clk);
        model_update(r, s, rv, rp);
        @(negedge clk);
    endtask

    initial begin
        logic        r, s, rv;
        logic [31:0] rp;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        @(negedge clk);

        // Reset, then free run
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("rst_addr0", imem_addr, 32'd0);
        step(0, 0, 0, 0);
        chk("run_addr1", imem_addr, 32'd1);
        step(0, 0, 0, 0);
        chk("run_first_instr", if_instr, 32'hA000_00AA);
        step(0, 0, 0, 0);
        chk("run_second_instr", if_instr, 32'h1000_0011);

        // Stall three cycles with a word in flight
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_frozen_instr", if_instr, 32'h1000_0011);
        chk("stall_frozen_addr", imem_addr, 32'd3);
        step(0, 0, 0, 0);
        chk("release_skid", if_instr, 32'h2000_0022);
        step(0, 0, 0, 0);
        chk("release_next", if_instr, 32'h3000_0033);

        // Redirect while if_pc = 4
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("redir_at_pc4", if_pc, 32'h4);
        step(0, 0, 1, 32'h20);
        chk("redir_valid0", {31'b0, if_valid}, 32'd0);
        chk("redir_nop", if_instr, NOP_INSTR);
        chk("redir_addr", imem_addr, 32'd8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("redir_target_instr", if_instr, 32'h8000_0088);
        chk("redir_target_pc", if_pc, 32'h20);

        // Redirect during stall with skid full, unaligned target
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("skid_full", {31'b0, dut.s_vld_q}, 32'd1);
        step(0, 1, 1, 32'h23);
        chk("skid_dropped", {31'b0, dut.s_vld_q}, 32'd0);
        chk("redir2_addr", imem_addr, 32'd8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("redir2_pc", if_pc, 32'h20);

        // Mid-stream reset while stalled
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("midrst_valid0", {31'b0, if_valid}, 32'd0);
        chk("midrst_nop", if_instr, NOP_INSTR);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("midrst_restart_pc", if_pc, RESET_PC);
        chk("midrst_restart_instr", if_instr, 32'hA000_00AA);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", if_pc_plus4, 32'd0);
        step(0, 0, 0, 0);
        chk("wrap_pc_next", if_pc, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 15) == 0);
            rp = $urandom();
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | {28'd0, rp[3:0]};
            step(r, s, rv, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
